prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream memory loader for the single-cycle RV32I processor: it holds the core in reset, accepts a length-prefixed stream of bytes over a valid/ready handshake, assembles them little-endian into 32-bit words, and writes them to consecutive word addresses of the processor memory. It is the write side of the data-memory path: it fills memory before execution, while the benches read result words back out of memory after execution. The loader sits between an external byte source and the memory write port, and drives the core's hold input.

## Interface
- ADDR_W, 8, byte-address width of the memory write port
- BASE_ADDR, 0, byte address of the first word written; must be a multiple of 4

- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  source presents a byte on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte; a transfer occurs on an edge with in_valid && in_ready
- mem_we  out  1  one-cycle word write strobe
- mem_addr  out  ADDR_W  byte address of the word being written, always 4-aligned
- mem_wdata  out  32  word data; byte 0 of the group in [7:0]
- cpu_hold  out  1  holds the processor in reset while 1
- done  out  1  load finished (sticky until reset)
- error  out  1  checksum mismatch (sticky until reset)
- words_loaded  out  16  count of words written so far

## Operation
- States: CNT_LO -> CNT_HI -> DATA -> (CHK) -> FLUSH -> DONE.
- CNT_LO, CNT_HI: take the 16-bit word count N, low byte first.
- After CNT_HI, with N == 0 go directly to CHK if the checksum is enabled, otherwise to FLUSH.
- DATA: shift bytes into a 32-bit assembly register, little-endian. The first byte is [7:0]; the fourth byte is [31:24].
- On acceptance of the 4th byte of a group:
  - register mem_wdata;
  - register mem_addr = BASE_ADDR + 4*k (mod 2^ADDR_W), where k is words_loaded;
  - pulse mem_we for the next cycle;
  - increment words_loaded.
- Leave DATA when the 4th byte of word N is accepted.
- FLUSH: one cycle, so the final write completes while cpu_hold is still 1.
- DONE: in_ready = 0; done = 1; cpu_hold = 0, or 1 if error. Further stream bytes are ignored.
- Address wrap: mem_addr wraps modulo 2^ADDR_W without error. Later words overwrite earlier ones.
- Reset mid-load: all state is discarded immediately. The next transfer is treated as the count low byte, and no partial word is written.

## Timing
- Reset values:
  - in_ready = 1, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0
  - cpu_hold = 1, done = 0, error = 0, words_loaded = 0
  - state = CNT_LO
- in_ready = 1 in CNT_LO, CNT_HI, DATA and CHK. It is 0 in FLUSH and DONE.
- Back-to-back bytes are accepted every cycle. The write pipeline never stalls input.
- Write latency: mem_we is high in the cycle after the edge that accepts the 4th byte, for exactly one cycle.
- Final byte accepted at edge E:
  - last mem_we is high during E..E+1;
  - the FLUSH state spans E..E+1;
  - done rises and cpu_hold falls at E+1.
- With N == 0 and the checksum disabled, done rises one cycle after the CNT_HI edge.
- in_valid gaps of any length are legal. The state machine holds.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined:
  - one extra byte follows the data and is accepted in CHK;
  - the expected value is the 8-bit modulo-256 sum of all data bytes, excluding the count bytes;
  - if the received byte differs from this sum, error = 1 and cpu_hold stays 1 in DONE;
  - words already written stay written.
- Macro undefined:
  - the CHK state and the sum logic are absent;
  - error is constant 0;
  - the stream ends after the last data byte.

## Test plan
- Load with checksum off: stream 02 00 78 56 34 12 EF BE AD DE -> mem_we at 0x00 with 0x12345678, then at 0x04 with 0xDEADBEEF; words_loaded = 2; done = 1 and cpu_hold = 0 one cycle after the last write.
- Backpressure-free gaps: same stream with in_valid low for 3 cycles between each byte -> identical writes and data; exactly 2 mem_we pulses.
- Zero count: stream 00 00 -> no mem_we; done one cycle after the 2nd byte; then in_ready = 0 and further bytes are ignored.
- Reset mid-load: assert reset after 6 bytes of the 2-word stream, then replay the full stream -> the first write is 0x12345678 at 0x00; no write of the partial pre-reset group.
- Address wrap with ADDR_W = 4: count 5 and words 1..5 -> addresses 0, 4, 8, C, then 0 with data 5; done = 1 and error = 0.
- Checksum (macro defined): stream 01 00 01 02 03 04 followed by 0A -> error = 0 and cpu_hold = 0. Same stream followed by 0B -> error = 1, done = 1, cpu_hold = 1, and word 0x04030201 still written.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: length-prefixed byte stream to 32-bit little-endian memory words, holding the core in reset while loading.
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);
  typedef enum logic [2:0] {
    S_CNT_LO, S_CNT_HI, S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FLUSH, S_DONE
  } state_t;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_FLUSH;
`endif
  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
  state_t            r_state, w_next;
  logic [15:0]       r_cnt, r_words;
  logic [23:0]       r_asm;
  logic [1:0]        r_bidx;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              w_acc, w_last_byte, w_last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
  logic              r_error;
  assign error = r_error;
`else
  assign error = 1'b0;
`endif
  assign in_ready     = (r_state != S_FLUSH) && (r_state != S_DONE);
  assign w_acc        = in_valid && in_ready;
  assign w_last_byte  = r_bidx == 2'd3;
  assign w_last_word  = (r_words + 16'd1) == r_cnt;
  assign done         = r_state == S_DONE;
  assign cpu_hold     = !done || error;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign words_loaded = r_words;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_CNT_LO;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CNT_LO: w_next = w_acc ? S_CNT_HI : r_state;
      S_CNT_HI: w_next = !w_acc ? r_state : ({in_data, r_cnt[7:0]} == 16'd0) ? S_TAIL : S_DATA;
      S_DATA:   w_next = (w_acc && w_last_byte && w_last_word) ? S_TAIL : r_state;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:    w_next = w_acc ? S_FLUSH : r_state;
`endif
      S_FLUSH:  w_next = S_DONE;
      default:  w_next = r_state;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt       <= '0;
      r_words     <= '0;
      r_asm       <= '0;
      r_bidx      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= L_BASE;
      r_mem_wdata <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum       <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      if (w_acc && r_state == S_CNT_LO) r_cnt[7:0] <= in_data;
      if (w_acc && r_state == S_CNT_HI) r_cnt[15:8] <= in_data;
      if (w_acc && r_state == S_DATA) begin
        r_bidx <= r_bidx + 2'd1;
        r_asm  <= {in_data, r_asm[23:8]};
`ifdef PROG_LOADER_CHECKSUM_EN
        r_sum  <= r_sum + in_data;
`endif
        if (w_last_byte) begin
          r_mem_we    <= 1'b1;
          r_mem_wdata <= {in_data, r_asm};
          r_mem_addr  <= L_BASE + ADDR_W'({r_words, 2'b00});
          r_words     <= r_words + 16'd1;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (w_acc && r_state == S_CHK) r_error <= in_data != r_sum;
`endif
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized stream loads checked by a write scoreboard and end-of-load status checks.
module tb_prog_loader;
  localparam int BASE = 0;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_hold, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_loaded;
  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t        exp_q[$];
  logic [7:0] q[$];
  int         vectors = 0, errs = 0;
  always #5 clk = ~clk;
  prog_loader #(.ADDR_W(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (mem_we === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, e.a});
        chk("mem_wdata", mem_wdata, e.d);
      end
    end
  task automatic expect_writes(input int sent);
    int n = {16'd0, q[1], q[0]};
    int full = (sent < 2) ? 0 : (sent - 2) / 4;
    if (full > n) full = n;
    for (int k = 0; k < full; k++)
      exp_q.push_back('{a: 8'((BASE + 4 * k) % 256),
                        d: {q[4*k+5], q[4*k+4], q[4*k+3], q[4*k+2]}});
  endtask
  task automatic add_chk(input bit bad);
    logic [7:0] s = 8'h00;
    for (int i = 2; i < q.size(); i++) s = s + q[i];
    q.push_back(bad ? s + 8'h01 : s);
  endtask
  task automatic make_rand(input int n);
    q.delete();
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom_range(0, 255)));
  endtask
  task automatic send_bytes(input int sent, input int gmin, input int gmax);
    expect_writes(sent);
    for (int i = 0; i < sent; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      chk("in_ready while loading", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = q[i];
      @(posedge clk);
    end
  endtask
  task automatic finish_load(input int words, input bit err);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready in FLUSH", {31'd0, in_ready}, 32'd0);
    chk("done in FLUSH", {31'd0, done}, 32'd0);
    chk("cpu_hold in FLUSH", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    chk("done", {31'd0, done}, 32'd1);
    chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, err});
    chk("error", {31'd0, error}, {31'd0, err});
    chk("words_loaded", {16'd0, words_loaded}, words);
    chk("pending writes", exp_q.size(), 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask
  initial begin
    bit bad;
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_addr", {24'd0, mem_addr}, BASE);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset error", {31'd0, error}, 32'd0);
    chk("reset words_loaded", {16'd0, words_loaded}, 32'd0);
    for (int g = 0; g < 4; g += 3) begin
      q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef PROG_LOADER_CHECKSUM_EN
      add_chk(1'b0);
`endif
      send_bytes(q.size(), g, g);
      finish_load(2, 1'b0);
      do_reset();
    end
    q = '{8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    add_chk(1'b0);
`endif
    send_bytes(q.size(), 0, 0);
    finish_load(0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h55;
      chk("in_ready in DONE", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("ignored bytes words_loaded", {16'd0, words_loaded}, 32'd0);
    chk("ignored bytes done", {31'd0, done}, 32'd1);
    do_reset();
    q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_bytes(8, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-reset writes", exp_q.size(), 32'd0);
    do_reset();
    chk("mid-load reset words_loaded", {16'd0, words_loaded}, 32'd0);
    chk("mid-load reset done", {31'd0, done}, 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    add_chk(1'b0);
`endif
    send_bytes(q.size(), 0, 0);
    finish_load(2, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    add_chk(1'b1);
    send_bytes(q.size(), 0, 0);
    finish_load(1, 1'b1);
`endif
    for (int t = 0; t < 12; t++) begin
      do_reset();
      n   = $urandom_range(1, 6);
      bad = 1'($urandom_range(0, 1));
      make_rand(n);
`ifdef PROG_LOADER_CHECKSUM_EN
      add_chk(bad);
`else
      bad = 1'b0;
`endif
      send_bytes(q.size(), 0, 2);
      finish_load(n, bad);
    end
    do_reset();
    make_rand(70);
`ifdef PROG_LOADER_CHECKSUM_EN
    add_chk(1'b0);
`endif
    send_bytes(q.size(), 0, 0);
    finish_load(70, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
